// File: rtl/i2s_frame_serializer_pkg.sv
// Shared definitions for the I2S frame serializer: FSM states, frame geometry,
// default clock ratios and the frame assembly helper.
package i2s_frame_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FRAME_BITS    = 64;
  localparam int SAMPLE_W      = 16;
  localparam int DEF_MCLK_HALF = 4;
  localparam int DEF_SCLK_HALF = 16;

  // Frame image, MSB shifted out first: one-bit I2S delay, 16-bit sample,
  // 15 pad bits, for left then right.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [SAMPLE_W-1:0] l,
                                                        input logic [SAMPLE_W-1:0] r);
    return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
  endfunction

endpackage

// File: rtl/i2s_frame_serializer_clk_prescaler.sv
// Divides clk into a registered toggle output with a half-period of HALF clk
// cycles. When disabled the counter and output are held at 0. o_fall flags the
// clk edge on which the output goes from 1 to 0.
module clk_prescaler #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tog,
  output logic o_fall
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tog;

  // Half-period counter and toggle register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tog <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_tog <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_tog <= ~r_tog;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      r_tog <= r_tog;
    end
  end

  assign o_tog  = r_tog;
  assign o_fall = i_en && (r_cnt == LAST) && r_tog;

endmodule

// File: rtl/i2s_frame_serializer.sv
// I2S master transmitter: generates mclk/sclk/lrck and shifts out 64-bit
// frames built from a one-deep sample-pair buffer, repeating the previous
// pair (and flagging an underrun) when no new pair has arrived.
module i2s_frame_serializer
  import i2s_frame_serializer_pkg::*;
#(
  parameter int MCLK_HALF = DEF_MCLK_HALF,
  parameter int SCLK_HALF = DEF_SCLK_HALF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  state_t                  r_state, w_next;
  logic [1:0]              r_rst_sync;
  logic                    w_run, w_load, w_stop, w_sclk_fall, w_xfer;
  logic [5:0]              r_bcnt;
  logic [5:0]              w_bcnt_nxt;
  logic [FRAME_BITS-1:0]   r_frame, w_frame_new;
  logic                    r_buf_full;
  logic [SAMPLE_W-1:0]     r_buf_l, r_buf_r, r_last_l, r_last_r, w_pair_l, w_pair_r;
  logic                    r_lrck, r_sdata, r_underrun;
  logic [15:0]             r_underrun_cnt;

  clk_prescaler #(.HALF(MCLK_HALF)) u_mclk_div (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .o_tog(mclk), .o_fall()
  );

  clk_prescaler #(.HALF(SCLK_HALF)) u_sclk_div (
    .clk(clk), .rst_n(rst_n), .i_en(w_run), .o_tog(sclk), .o_fall(w_sclk_fall)
  );

  // Two-flop synchroniser on reset release; gates the IDLE exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable && r_rst_sync[1]) w_next = RUN;
               else                         w_next = IDLE;
      RUN:     if (!enable) w_next = DRAIN;
               else         w_next = RUN;
      DRAIN:   if (enable)                                w_next = RUN;
               else if (w_sclk_fall && (r_bcnt == 6'd63)) w_next = IDLE;
               else                                       w_next = DRAIN;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: prescaler run, frame load and end-of-drain strobes
  always_comb begin
    w_run  = 1'b0;
    w_load = 1'b0;
    w_stop = 1'b0;
    case (r_state)
      IDLE: begin
        w_run = 1'b0;
      end
      RUN: begin
        w_run  = 1'b1;
        w_load = w_sclk_fall && (r_bcnt == 6'd63);
      end
      DRAIN: begin
        w_run  = 1'b1;
        w_stop = w_sclk_fall && (r_bcnt == 6'd63) && !enable;
      end
      default: begin
        w_run = 1'b0;
      end
    endcase
  end

  // Pick buffered pair if present, otherwise repeat the last one used
  always_comb begin
    if (r_buf_full) begin
      w_pair_l = r_buf_l;
      w_pair_r = r_buf_r;
    end else begin
      w_pair_l = r_last_l;
      w_pair_r = r_last_r;
    end
  end

  assign w_frame_new = build_frame(w_pair_l, w_pair_r);
  assign w_bcnt_nxt  = r_bcnt + 6'd1;
  assign w_xfer      = in_valid && !r_buf_full;

  // Bit counter, frame shift register, lrck and sdata (change only on sclk fall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= 6'd63;
      r_frame <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
    end else if ((r_state == IDLE) || w_stop) begin
      r_bcnt  <= 6'd63;
      r_frame <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
    end else if (w_load) begin
      r_bcnt  <= 6'd0;
      r_frame <= w_frame_new;
      r_lrck  <= 1'b0;
      r_sdata <= w_frame_new[FRAME_BITS-1];
    end else if (w_sclk_fall) begin
      r_bcnt  <= w_bcnt_nxt;
      r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
      r_lrck  <= w_bcnt_nxt[5];
      r_sdata <= r_frame[FRAME_BITS-2];
    end else begin
      r_bcnt  <= r_bcnt;
      r_frame <= r_frame;
      r_lrck  <= r_lrck;
      r_sdata <= r_sdata;
    end
  end

  // One-deep holding buffer; a same-edge transfer waits for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
    end else if (w_xfer) begin
      r_buf_full <= 1'b1;
      r_buf_l    <= in_left;
      r_buf_r    <= in_right;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
      r_buf_l    <= r_buf_l;
      r_buf_r    <= r_buf_r;
    end else begin
      r_buf_full <= r_buf_full;
      r_buf_l    <= r_buf_l;
      r_buf_r    <= r_buf_r;
    end
  end

  // Remember the pair most recently placed into a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_load && r_buf_full) begin
      r_last_l <= r_buf_l;
      r_last_r <= r_buf_r;
    end else begin
      r_last_l <= r_last_l;
      r_last_r <= r_last_r;
    end
  end

  // Underrun pulse and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= 16'd0;
    end else if (w_load && !r_buf_full) begin
      r_underrun     <= 1'b1;
      r_underrun_cnt <= (r_underrun_cnt == 16'hFFFF) ? r_underrun_cnt
                                                     : r_underrun_cnt + 16'd1;
    end else begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= r_underrun_cnt;
    end
  end

  assign in_ready     = !r_buf_full;
  assign lrck         = r_lrck;
  assign sdata        = r_sdata;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Directed bench for i2s_frame_serializer: table of sample pairs with
// hand-computed 64-slot frame images, plus sequences for underrun, same-edge
// transfer, drain, mid-frame reset and counter saturation.
module tb_i2s_frame_serializer;

  localparam int SCLK_HALF  = 16;
  localparam int MCLK_HALF  = 4;
  localparam int FRAME_CLK  = 128 * SCLK_HALF;
  localparam int FALL_BOUND = 200;
  localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

  logic        clk, rst_n, enable, in_valid, in_ready;
  logic [15:0] in_left, in_right, underrun_cnt;
  logic        mclk, sclk, lrck, sdata, underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int und_pulses = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] frame;   // slot 0 at bit 63
  } vec_t;
  vec_t vecs[4];

  i2s_frame_serializer #(.MCLK_HALF(MCLK_HALF), .SCLK_HALF(SCLK_HALF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
    .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdata(sdata),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (underrun === 1'b1) und_pulses <= und_pulses + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_fall(output bit ok);
    logic prev;
    prev = sclk;
    ok = 1'b0;
    for (int n = 0; n < FALL_BOUND; n++) begin
      @(negedge clk);
      if (prev === 1'b1 && sclk === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = sclk;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL sclk_fall_timeout: no falling sclk within %0d clk", FALL_BOUND);
    end
  endtask

  task automatic sample_slot(input int k, inout logic [63:0] b, inout logic [63:0] l);
    b[63-k] = sdata;
    l[63-k] = lrck;
  endtask

  task automatic capture_rest(input int from, inout logic [63:0] b, inout logic [63:0] l);
    bit ok;
    for (int k = from; k < 64; k++) begin
      next_fall(ok);
      sample_slot(k, b, l);
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Observe n negedges: mclk interval violations, mclk change count, any sclk/lrck/sdata high
  task automatic quiet_window(input int n, output int m_bad, output int m_chg, output int s_high);
    logic pm;
    int   last;
    pm = mclk; last = -1; m_bad = 0; m_chg = 0; s_high = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mclk !== pm) begin
        if (last >= 0 && (i - last) != MCLK_HALF) m_bad++;
        last = i;
        m_chg++;
      end
      pm = mclk;
      if (sclk !== 1'b0 || lrck !== 1'b0 || sdata !== 1'b0) s_high++;
    end
  endtask

  initial begin
    logic [63:0] fb, lb;
    int t_prev, t_now, m_bad, m_chg, s_high;
    bit ok;

    vecs[0] = '{16'h8001, 16'h7FFE, 64'h4000_8000_3FFF_0000};
    vecs[1] = '{16'h1234, 16'hABCD, 64'h091A_0000_55E6_8000};
    vecs[2] = '{16'hFFFF, 16'h0000, 64'h7FFF_8000_0000_0000};
    vecs[3] = '{16'h0000, 16'hFFFF, 64'h0000_0000_7FFF_8000};

    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_left = 16'h0; in_right = 16'h0;
    t_prev = 0;
    repeat (3) @(negedge clk);
    check("rst_mclk", mclk, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_lrck", lrck, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ucnt", underrun_cnt, 16'h0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Idle: mclk runs, serial outputs quiet
    quiet_window(40, m_bad, m_chg, s_high);
    check("idle_mclk_interval", m_bad, 0);
    check("idle_mclk_changes", m_chg, 10);
    check("idle_serial_quiet", s_high, 0);

    // Buffer accepts one pair while idle
    check("idle_ready_before", in_ready, 1'b1);
    offer(vecs[0].l, vecs[0].r);
    check("idle_ready_after", in_ready, 1'b0);

    // Table-driven frames, each pair fed during the previous frame
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fb = '0; lb = '0;
      next_fall(ok);
      t_now = cyc;
      sample_slot(0, fb, lb);
      check($sformatf("vec%0d_underrun", i), underrun, 1'b0);
      if (i > 0) check($sformatf("vec%0d_period", i), t_now - t_prev, FRAME_CLK);
      t_prev = t_now;
      if (i < 3) begin
        check($sformatf("vec%0d_ready", i), in_ready, 1'b1);
        offer(vecs[i+1].l, vecs[i+1].r);
        check($sformatf("vec%0d_full", i), in_ready, 1'b0);
      end
      capture_rest(1, fb, lb);
      check($sformatf("vec%0d_frame", i), fb, vecs[i].frame);
      check($sformatf("vec%0d_lrck", i), lb, LR_EXP);
    end
    check("vec_no_underrun", und_pulses, 0);

    // No new samples: previous pair repeats, one underrun per frame
    for (int j = 0; j < 3; j++) begin
      fb = '0; lb = '0;
      next_fall(ok);
      t_now = cyc;
      sample_slot(0, fb, lb);
      check($sformatf("urun%0d_pulse", j), underrun, 1'b1);
      check($sformatf("urun%0d_cnt", j), underrun_cnt, 16'(j + 1));
      check($sformatf("urun%0d_period", j), t_now - t_prev, FRAME_CLK);
      t_prev = t_now;
      capture_rest(1, fb, lb);
      check($sformatf("urun%0d_frame", j), fb, vecs[3].frame);
    end
    check("urun_pulses", und_pulses, 3);

    // Transfer on the exact frame-load edge
    repeat (2 * SCLK_HALF - 1) @(negedge clk);
    offer(16'hA5A5, 16'h5A5A);
    fb = '0; lb = '0;
    sample_slot(0, fb, lb);
    check("coll_underrun", underrun, 1'b1);
    check("coll_cnt", underrun_cnt, 16'd4);
    check("coll_ready", in_ready, 1'b0);
    check("coll_period", cyc - t_prev, FRAME_CLK);
    capture_rest(1, fb, lb);
    check("coll_frame", fb, vecs[3].frame);
    check("coll_ready_end", in_ready, 1'b0);
    fb = '0; lb = '0;
    next_fall(ok);
    sample_slot(0, fb, lb);
    check("after_coll_underrun", underrun, 1'b0);
    check("after_coll_ready", in_ready, 1'b1);
    capture_rest(1, fb, lb);
    check("after_coll_frame", fb, 64'h52D2_8000_2D2D_0000);
    check("after_coll_cnt", underrun_cnt, 16'd4);

    // Drain: enable dropped at bcnt 10, frame still completes
    fb = '0; lb = '0;
    next_fall(ok);
    sample_slot(0, fb, lb);
    check("drain_start_cnt", underrun_cnt, 16'd5);
    for (int k = 1; k < 64; k++) begin
      next_fall(ok);
      sample_slot(k, fb, lb);
      if (k == 10) enable = 1'b0;
    end
    check("drain_frame", fb, 64'h52D2_8000_2D2D_0000);
    check("drain_lrck", lb, LR_EXP);
    repeat (2 * SCLK_HALF + 2) @(negedge clk);
    check("drain_sclk", sclk, 1'b0);
    check("drain_lrck_end", lrck, 1'b0);
    check("drain_sdata_end", sdata, 1'b0);
    quiet_window(300, m_bad, m_chg, s_high);
    check("drain_mclk_interval", m_bad, 0);
    check("drain_mclk_changes", m_chg, 75);
    check("drain_serial_quiet", s_high, 0);
    check("drain_no_underrun", und_pulses, 5);
    check("drain_cnt_hold", underrun_cnt, 16'd5);

    // Reset at bcnt 40 with a pair waiting in the buffer
    enable = 1'b1;
    fb = '0; lb = '0;
    next_fall(ok);
    check("rerun_cnt", underrun_cnt, 16'd6);
    for (int k = 1; k <= 40; k++) begin
      next_fall(ok);
      if (k == 20) offer(16'h1111, 16'h2222);
    end
    check("prereset_full", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mclk", mclk, 1'b0);
    check("mid_rst_sclk", sclk, 1'b0);
    check("mid_rst_lrck", lrck, 1'b0);
    check("mid_rst_sdata", sdata, 1'b0);
    check("mid_rst_underrun", underrun, 1'b0);
    check("mid_rst_cnt", underrun_cnt, 16'h0);
    check("mid_rst_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fb = '0; lb = '0;
    next_fall(ok);
    sample_slot(0, fb, lb);
    check("post_rst_underrun", underrun, 1'b1);
    check("post_rst_cnt", underrun_cnt, 16'd1);
    capture_rest(1, fb, lb);
    check("post_rst_frame", fb, 64'h0);
    check("post_rst_lrck", lb, LR_EXP);

    // Saturation of the underrun counter
    force dut.r_underrun_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_underrun_cnt;
    for (int j = 0; j < 3; j++) begin
      fb = '0; lb = '0;
      next_fall(ok);
      check($sformatf("sat%0d_pulse", j), underrun, 1'b1);
      check($sformatf("sat%0d_cnt", j), underrun_cnt, 16'hFFFF);
      capture_rest(1, fb, lb);
    end
    check("total_pulses", und_pulses, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
